// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - four-digit multiplexed 7-segment scan controller
// Per-slot blanking, masked-digit skipping and an end-of-sweep pulse.
module varredura_display #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] mascara,
  output logic [1:0] seletor,
  output logic [3:0] digitos,
  output logic       quadro
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cont, cont_next;
  logic [1:0]    sel_next;
  logic [3:0]    mascara_q;
  logic [3:0]    dig_next;
  logic          quadro_next;
  logic          in_blank;

  // First enabled digit in order s+1, s+2, s+3, s; holds when nothing is enabled.
  function automatic logic [1:0] next_idx(input logic [1:0] s, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = s;
    for (int i = 4; i >= 1; i--) begin
      c = s + 2'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  always_comb begin
    cont_next   = cont;
    sel_next    = seletor;
    quadro_next = 1'b0;
    if (habilita) begin
      if (cont == LAST) begin
        cont_next   = '0;
        sel_next    = next_idx(seletor, mascara_q);
        quadro_next = (sel_next <= seletor);
      end else begin
        cont_next = cont + 1'b1;
      end
    end
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cont_next < BLANK_C);
    end
  endgenerate

  // Anodes come from next-state values so they line up with seletor on the same edge.
  always_comb begin
    dig_next = 4'b1111;
    if (habilita && !in_blank && mascara[sel_next])
      dig_next = ~(4'b0001 << sel_next);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cont      <= '0;
      seletor   <= 2'd0;
      mascara_q <= 4'b0000;
      digitos   <= 4'b1111;
      quadro    <= 1'b0;
    end else begin
      cont      <= cont_next;
      seletor   <= sel_next;
      mascara_q <= mascara;
      digitos   <= dig_next;
      quadro    <= quadro_next;
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - vector-table bench for varredura_display
module tb_varredura_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [3:0] mascara = 4'b0000;

  logic [1:0] sel_a, sel_b;
  logic [3:0] dig_a, dig_b;
  logic       q_a, q_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  varredura_display #(.DIV(8), .BLANK(2)) dut_a (
    .clock(clock), .reset(reset), .habilita(habilita), .mascara(mascara),
    .seletor(sel_a), .digitos(dig_a), .quadro(q_a)
  );

  varredura_display #(.DIV(2), .BLANK(0)) dut_b (
    .clock(clock), .reset(reset), .habilita(habilita), .mascara(mascara),
    .seletor(sel_b), .digitos(dig_b), .quadro(q_b)
  );

  typedef struct {
    logic       use_b;
    logic       rst;
    logic       hab;
    logic [3:0] msk;
    logic [1:0] sel;
    logic [3:0] dig;
    logic       q;
    string      tag;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic use_b, input logic rst, input logic hab, input logic [3:0] msk,
                     input logic [1:0] sel, input logic [3:0] dig, input logic q, input string tag);
    vec_t v;
    v.use_b = use_b; v.rst = rst; v.hab = hab; v.msk = msk;
    v.sel = sel; v.dig = dig; v.q = q; v.tag = tag;
    vq.push_back(v);
  endtask

  // Full-mask reference: k edges after the reset edge, slot n = k/div, count c = k%div.
  task automatic add_full(input logic use_b, input int k, input int div, input int blank,
                          input logic hab, input string tag);
    int n, c;
    logic [1:0] s;
    logic [3:0] one;
    n = k / div;
    c = k % div;
    s = 2'(n % 4);
    one = 4'b0001;
    add(use_b, (k == 0), hab, 4'b1111, s,
        (k == 0 || c < blank) ? 4'b1111 : ~(one << s),
        (c == 0 && n > 0 && (n % 4) == 0), tag);
  endtask

  task automatic cmp(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%b required=%b", name, k, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      reset    = vq[i].rst;
      habilita = vq[i].hab;
      mascara  = vq[i].msk;
      @(posedge clock);
      #1;
      if (vq[i].use_b) begin
        cmp({vq[i].tag, ".seletor"}, i, {2'b00, sel_b}, {2'b00, vq[i].sel});
        cmp({vq[i].tag, ".digitos"}, i, dig_b, vq[i].dig);
        cmp({vq[i].tag, ".quadro"},  i, {3'b000, q_b}, {3'b000, vq[i].q});
      end else begin
        cmp({vq[i].tag, ".seletor"}, i, {2'b00, sel_a}, {2'b00, vq[i].sel});
        cmp({vq[i].tag, ".digitos"}, i, dig_a, vq[i].dig);
        cmp({vq[i].tag, ".quadro"},  i, {3'b000, q_a}, {3'b000, vq[i].q});
      end
    end
    vq.delete();
  endtask

  initial begin
    int n, c;
    logic [1:0] s;

    // Full sweep 0,1,2,3,0 with 2-cycle blanking.
    for (int k = 0; k <= 40; k++) add_full(1'b0, k, 8, 2, 1'b1, "sweep");
    run_table();

    // Mask 1010: dark slot 0, then 1,3,1,3 with a pulse on each 3->1.
    for (int k = 0; k <= 48; k++) begin
      n = k / 8; c = k % 8;
      s = (n == 0) ? 2'd0 : ((n % 2) == 1 ? 2'd1 : 2'd3);
      add(1'b0, (k == 0), 1'b1, 4'b1010, s,
          (n == 0 || c < 2) ? 4'b1111 : (s == 2'd1 ? 4'b1101 : 4'b0111),
          (c == 0 && n >= 3 && (n % 2) == 1), "skip");
    end
    run_table();

    // Single digit 2: pulse every slot once it is reached.
    for (int k = 0; k <= 40; k++) begin
      n = k / 8; c = k % 8;
      add(1'b0, (k == 0), 1'b1, 4'b0100, (n == 0) ? 2'd0 : 2'd2,
          (n >= 1 && c >= 2) ? 4'b1011 : 4'b1111, (c == 0 && n >= 2), "single");
    end
    run_table();

    // Everything masked: dark, seletor holds, pulse every slot.
    for (int k = 0; k <= 24; k++) begin
      n = k / 8; c = k % 8;
      add(1'b0, (k == 0), 1'b1, 4'b0000, 2'd0, 4'b1111, (c == 0 && n >= 1), "none");
    end
    run_table();

    // Freeze in slot 1 at cont=5 for 10 cycles, then finish the slot.
    for (int k = 0; k <= 40; k++) begin
      if (k <= 13)      add_full(1'b0, k, 8, 2, 1'b1, "freeze");
      else if (k <= 23) add(1'b0, 1'b0, 1'b0, 4'b1111, 2'd1, 4'b1111, 1'b0, "freeze_hold");
      else              add_full(1'b0, k - 10, 8, 2, 1'b1, "freeze_resume");
    end
    run_table();

    // Reset at cont=4, seletor=2; scan restarts from slot 0.
    for (int k = 0; k <= 20; k++) add_full(1'b0, k, 8, 2, 1'b1, "pre_reset");
    for (int k = 0; k <= 12; k++) add_full(1'b0, k, 8, 2, 1'b1, "mid_reset");
    run_table();

    // Clear mascara[1] while digit 1 is lit; next slot goes to 2.
    for (int k = 0; k <= 23; k++) begin
      if (k <= 11)      add_full(1'b0, k, 8, 2, 1'b1, "unmask");
      else if (k <= 15) add(1'b0, 1'b0, 1'b1, 4'b1101, 2'd1, 4'b1111, 1'b0, "unmask_dark");
      else              add(1'b0, 1'b0, 1'b1, 4'b1101, 2'd2,
                            (k - 16 < 2) ? 4'b1111 : 4'b1011, 1'b0, "unmask_next");
    end
    run_table();

    // DIV=2, BLANK=0: lit in both cycles of every slot.
    for (int k = 0; k <= 20; k++) add_full(1'b1, k, 2, 0, 1'b1, "div2");
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
